// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared types and constants for the SPI memory slave.
//   spi_state_e : SPI frame FSM states
//   CMD_*       : two-bit command codes carried in the top bits of every frame
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_mem_ram.sv
// spi_mem_ram: single-port RAM with write/read address registers and command
// decode for the SPI memory slave.
//   clk, rst    : clock, synchronous active-high reset (RAM contents not reset)
//   rx_data     : {cmd[1:0], payload[W-1:0]}, qualified by rx_valid
//   rx_valid    : one-cycle strobe for a completed frame
//   tx_data     : read data, qualified by tx_valid (one cycle after rx_valid)
//   tx_valid    : one-cycle strobe for a cmd-11 read
//   rd_addr_ok  : a read address has been latched and a cmd-11 read may follow
// Optional build macro SPI_MEM_AUTOINC_EN: post-increment both addresses
// (wrapping at MEM_DEPTH) and keep rd_addr_ok set after reads.
module spi_mem_ram
  import spi_mem_pkg::*;
#(
  parameter int W         = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W+1:0] rx_data,
  input  logic         rx_valid,
  output logic [W-1:0] tx_data,
  output logic         tx_valid,
  output logic         rd_addr_ok
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [W:0] DEPTH_C = (W+1)'(MEM_DEPTH);

  logic [W-1:0] mem [0:MEM_DEPTH-1];
  logic [W-1:0] wr_addr;
  logic [W-1:0] rd_addr;
  logic [1:0]   cmd;
  logic [W-1:0] payload;

  assign cmd     = rx_data[W+1:W];
  assign payload = rx_data[W-1:0];

  // Addresses are W bits wide but the RAM may be shallower than 2**W.
  function automatic logic in_range(input logic [W-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

`ifdef SPI_MEM_AUTOINC_EN
  localparam logic [W-1:0] LAST_ADDR = W'(MEM_DEPTH - 1);

  function automatic logic [W-1:0] next_addr(input logic [W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction
`endif

  // RAM array kept free of reset so it maps onto memory.
  always_ff @(posedge clk) begin
    if (!rst && rx_valid && cmd == CMD_WR_DATA && in_range(wr_addr))
      mem[wr_addr[AW-1:0]] <= payload;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      rd_addr_ok <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= payload;
          CMD_WR_DATA: begin
`ifdef SPI_MEM_AUTOINC_EN
            wr_addr <= next_addr(wr_addr);
`endif
          end
          CMD_RD_ADDR: begin
            rd_addr    <= payload;
            rd_addr_ok <= 1'b1;
          end
          default: begin // CMD_RD_DATA: payload bits are dummies
            tx_valid <= 1'b1;
            tx_data  <= in_range(rd_addr) ? mem[rd_addr[AW-1:0]] : '0;
`ifdef SPI_MEM_AUTOINC_EN
            rd_addr  <= next_addr(rd_addr);
`else
            rd_addr_ok <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_mem_slave.sv
// spi_mem_slave: SPI slave front end for a small RAM. clk doubles as the SPI
// bit clock. A frame is SS_n low for one setup cycle, then W+2 MOSI bits
// (cmd[1:0] then payload, MSB first).
//   clk, rst   : clock, synchronous active-high reset
//   SS_n       : active-low slave select / frame delimiter
//   MOSI       : serial data in, sampled on rising clk
//   MISO       : registered serial read data, MSB first
//   frame_err  : one-cycle pulse when SS_n rises before a frame completes
//   state_dbg  : current FSM state encoding (spi_state_e)
// Optional build macro SPI_MEM_AUTOINC_EN: see spi_mem_ram.
// Handshake: rx_valid and tx_valid are single-cycle strobes with no ready;
// the consumer must act in the cycle the strobe is high.
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int W         = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       frame_err,
  output logic [2:0] state_dbg
);

  localparam int CW = $clog2(W + 3);
  localparam int TW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(W + 1);
  localparam logic [CW-1:0] FULL     = CW'(W + 2);

  spi_state_e   state, state_next;
  logic [CW-1:0] bit_cnt;
  logic [W+1:0]  shreg;
  logic [W+1:0]  rx_data;
  logic          rx_valid;
  logic [W-1:0]  tx_data;
  logic          tx_valid;
  logic          rd_addr_ok;
  logic [W-1:0]  tx_shreg;
  logic [TW-1:0] tx_left;
  logic          rd_pending;
  logic          frame_open;
  logic          in_data_state;

  assign state_dbg     = state;
  assign in_data_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

  // A frame that entered READ_ADD because no read address was latched is
  // decoded as an address latch whatever its second command bit says.
  assign rx_data = (state == READ_ADD) ? {CMD_RD_ADDR, shreg[W-1:0]} : shreg;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!SS_n) state_next = CHK_CMD;
      CHK_CMD: begin
        if (SS_n)            state_next = IDLE;
        else if (!MOSI)      state_next = WRITE;
        else if (rd_addr_ok) state_next = READ_DATA;
        else                 state_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: if (SS_n) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Frame receive: the command bit seen in CHK_CMD is bit 1; once all W+2
  // bits are in, further MOSI is ignored until SS_n rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == CHK_CMD && !SS_n) begin
        shreg   <= {shreg[W:0], MOSI};
        bit_cnt <= CW'(1);
      end else if (in_data_state && !SS_n && bit_cnt != FULL) begin
        shreg   <= {shreg[W:0], MOSI};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) rx_valid <= 1'b1;
      end else if (state == IDLE) begin
        bit_cnt <= '0;
      end
    end
  end

  // Read data goes out the cycle after tx_valid; MISO is forced low whenever
  // the FSM is not going to be in READ_DATA next cycle.
  always_ff @(posedge clk) begin
    if (rst || state_next != READ_DATA) begin
      MISO     <= 1'b0;
      tx_shreg <= '0;
      tx_left  <= '0;
    end else if (tx_valid) begin
      MISO     <= tx_data[W-1];
      tx_shreg <= tx_data << 1;
      tx_left  <= TW'(W - 1);
    end else if (tx_left != '0) begin
      MISO     <= tx_shreg[W-1];
      tx_shreg <= tx_shreg << 1;
      tx_left  <= tx_left - 1'b1;
    end else begin
      MISO <= 1'b0;
    end
  end

  // A read counts as unfinished until its last data bit has been loaded.
  assign rd_pending = (rx_valid && rx_data[W+1:W] == CMD_RD_DATA) || tx_valid || (tx_left != '0);

  always_comb begin
    frame_open = 1'b0;
    case (state)
      CHK_CMD:          frame_open = 1'b1;
      WRITE, READ_ADD:  frame_open = (bit_cnt != FULL);
      READ_DATA:        frame_open = (bit_cnt != FULL) || rd_pending;
      default:          frame_open = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= SS_n && frame_open;
  end

  spi_mem_ram #(.W(W), .MEM_DEPTH(MEM_DEPTH)) u_ram (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .rd_addr_ok (rd_addr_ok)
  );

endmodule
